// File: rtl/dut_sched.sv
// Round-robin scheduler with burst locking that shares one in-order datapath
// among NREQ requesters, tracking outstanding issues in a tag FIFO for response routing.
module dut_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_OUT   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ-1:0]         i_lock,
  input  logic [NREQ*DW-1:0]      i_data,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_dp_valid,
  output logic [DW-1:0]           o_dp_data,
  output logic [$clog2(NREQ)-1:0] o_dp_id,
  input  logic                    i_dp_rvalid,
  input  logic [DW-1:0]           i_dp_rdata,
  output logic [NREQ-1:0]         o_rsp_valid,
  output logic [DW-1:0]           o_rsp_data,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W    = (IW + 1)'(NREQ);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUT);
  localparam logic [BW-1:0] BURST_LEN = BW'(MAX_BURST);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    return (k == LAST_IDX) ? '0 : k + 1'b1;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [BW-1:0]   r_beat, w_beat_nxt, w_beat_inc;
  logic [IW-1:0]   r_rr, w_rr_nxt;

  logic [IW-1:0]   r_tag [MAX_OUT];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic            r_dp_vld_p1;
  logic [DW-1:0]   r_dp_data_p1;
  logic [IW-1:0]   r_dp_id_p1;
  logic [NREQ-1:0] r_rsp_vld_p1;
  logic [DW-1:0]   r_rsp_data_p1;
  logic            r_busy_p1;
  logic            r_err;

  logic            w_arb_any, w_sel_any, w_credit, w_xfer, w_pop, w_stray;
  logic [IW-1:0]   w_arb_idx, w_sel_idx, w_head;
  logic [IW:0]     w_sum;
  logic [NREQ-1:0] w_gnt;
  logic [DW-1:0]   w_sel_data;

  // Scan downward so the lowest offset from rr wins.
  always_comb begin
    w_arb_any = 1'b0;
    w_arb_idx = '0;
    w_sum     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (IW + 1)'(i);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (i_req[w_sum[IW-1:0]]) begin
        w_arb_any = 1'b1;
        w_arb_idx = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    if (r_state == ST_ARB) begin
      w_sel_any = w_arb_any;
      w_sel_idx = w_arb_idx;
    end else begin
      w_sel_any = i_req[r_owner];
      w_sel_idx = r_owner;
    end
  end

  // Credit is judged on the registered count, so a return only frees a slot next cycle.
  assign w_credit   = (r_cnt != FULL_CNT);
  assign w_gnt      = (w_credit && w_sel_any && !reset) ? (NREQ'(1) << w_sel_idx) : '0;
  assign w_xfer     = |w_gnt;
  assign o_gnt      = w_gnt;
  assign w_beat_inc = r_beat + 1'b1;

  always_comb begin
    w_sel_data = i_data[int'(w_sel_idx) * DW +: DW];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat;
    w_rr_nxt    = r_rr;
    if (r_state == ST_ARB) begin
      if (w_xfer) begin
        if (i_lock[w_sel_idx] && (MAX_BURST > 1)) begin
          w_state_nxt = ST_BURST;
          w_owner_nxt = w_sel_idx;
          w_beat_nxt  = BW'(1);
        end else begin
          w_rr_nxt = next_idx(w_sel_idx);
        end
      end
    end else begin
      if (!i_req[r_owner] ||
          (w_xfer && (!i_lock[r_owner] || (w_beat_inc == BURST_LEN)))) begin
        w_state_nxt = ST_ARB;
        w_beat_nxt  = '0;
        w_rr_nxt    = next_idx(r_owner);
      end else if (w_xfer) begin
        w_beat_nxt = w_beat_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_owner <= '0;
      r_beat  <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beat  <= w_beat_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  assign w_pop     = i_dp_rvalid && (r_cnt != '0);
  assign w_stray   = i_dp_rvalid && (r_cnt == '0);
  assign w_head    = r_tag[r_rptr];
  assign w_cnt_nxt = r_cnt + CW'(w_xfer) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_xfer) r_tag[r_wptr] <= w_sel_idx;
  end

  // Stage p1: issue and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_cnt         <= '0;
      r_dp_vld_p1   <= 1'b0;
      r_dp_data_p1  <= '0;
      r_dp_id_p1    <= '0;
      r_rsp_vld_p1  <= '0;
      r_rsp_data_p1 <= '0;
      r_busy_p1     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_busy_p1    <= (w_cnt_nxt != '0);
      r_dp_vld_p1  <= w_xfer;
      r_rsp_vld_p1 <= w_pop ? (NREQ'(1) << w_head) : '0;
      if (w_xfer) begin
        r_wptr       <= r_wptr + 1'b1;
        r_dp_data_p1 <= w_sel_data;
        r_dp_id_p1   <= w_sel_idx;
      end
      if (w_pop) begin
        r_rptr        <= r_rptr + 1'b1;
        r_rsp_data_p1 <= i_dp_rdata;
      end
      if (w_stray) r_err <= 1'b1;
    end
  end

  assign o_dp_valid  = r_dp_vld_p1;
  assign o_dp_data   = r_dp_data_p1;
  assign o_dp_id     = r_dp_id_p1;
  assign o_rsp_valid = r_rsp_vld_p1;
  assign o_rsp_data  = r_rsp_data_p1;
  assign o_busy      = r_busy_p1;
  assign o_err       = r_err;

endmodule

// File: doc/dut_sched.md
DUT_SCHED -- requirements
Module: dut_sched

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one datapath instance.
REQ-002 Parameter DW, default 8, SHALL set the data width on all data ports.
REQ-003 Parameter MAX_OUT, default 4 (power of 2), SHALL set the maximum number of outstanding datapath transactions (tag FIFO depth).
REQ-004 Parameter MAX_BURST, default 4, SHALL set the maximum number of consecutive locked beats granted to one requester.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 i_req  in  NREQ  per-requester request.
REQ-008 i_lock  in  NREQ  per-requester burst-lock qualifier, sampled with i_req.
REQ-009 i_data  in  NREQ*DW  requester k data at bits [k*DW +: DW].
REQ-010 o_gnt  out  NREQ  combinational one-hot grant; beat transfers when i_req[k] & o_gnt[k].
REQ-011 o_dp_valid  out  1  registered issue strobe to shared datapath.
REQ-012 o_dp_data  out  DW  registered issued data.
REQ-013 o_dp_id  out  $clog2(NREQ)  registered index of issuing requester.
REQ-014 i_dp_rvalid  in  1  datapath result strobe; results return in issue order.
REQ-015 i_dp_rdata  in  DW  datapath result.
REQ-016 o_rsp_valid  out  NREQ  registered one-hot response strobe to owning requester.
REQ-017 o_rsp_data  out  DW  registered response data.
REQ-018 o_busy  out  1  high while outstanding count is non-zero.
REQ-019 o_err  out  1  sticky: i_dp_rvalid seen with no transaction outstanding.

Function
REQ-020 o_gnt SHALL be zero when outstanding count equals MAX_OUT (credit exhausted); a same-cycle return SHALL NOT free credit until the next cycle.
REQ-021 In state ARB, o_gnt SHALL select the first requesting index at or after round-robin pointer rr, wrapping NREQ-1 to 0.
REQ-022 After a non-locked transfer by k, rr SHALL become (k+1) mod NREQ.
REQ-023 A transfer by k with i_lock[k]=1 in ARB SHALL move FSM to BURST with owner=k, beat count=1.
REQ-024 In BURST, only owner SHALL be grantable; other requests SHALL wait regardless of rr.
REQ-025 BURST SHALL return to ARB with rr=(owner+1) mod NREQ when: owner transfers with i_lock=0; owner transfers and beat count reaches MAX_BURST; or owner deasserts i_req.
REQ-026 A transfer SHALL produce o_dp_valid=1, o_dp_data=i_data[k], o_dp_id=k exactly one cycle later; o_dp_valid=0 otherwise.
REQ-027 Each transfer SHALL push k into the tag FIFO; each i_dp_rvalid with FIFO non-empty SHALL pop head h.
REQ-028 A pop SHALL produce o_rsp_valid=one-hot(h), o_rsp_data=i_dp_rdata one cycle later; o_rsp_valid=0 otherwise.
REQ-029 Simultaneous push and pop SHALL leave outstanding count unchanged; push and pop at MAX_OUT-1/0 boundaries SHALL wrap FIFO pointers mod MAX_OUT.
REQ-030 i_dp_rvalid with FIFO empty SHALL be dropped (no o_rsp_valid) and SHALL set o_err until reset.
REQ-031 o_busy SHALL equal (outstanding count != 0), registered.

Reset
REQ-032 reset SHALL asynchronously force FSM=ARB, rr=0, beat count=0, FIFO empty, o_dp_valid=0, o_dp_data=0, o_dp_id=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_err=0.
REQ-033 Reset mid-burst or with outstanding transactions SHALL discard them; results arriving after reset release SHALL set o_err.

Verification
REQ-034 All four i_req=1, no lock, data 8'h10..8'h13, immediate returns -> grants 0,1,2,3,0 in order; o_dp_id 0,1,2,3 one cycle after each grant.
REQ-035 i_req[2]=1, i_lock[2]=1 held, i_req[0]=1 -> o_gnt=4'b0100 for exactly 4 beats, then 4'b0001; rr=3 after burst.
REQ-036 No returns, i_req[1]=1 continuous -> 4 transfers then o_gnt=0, o_busy=1; one i_dp_rvalid -> o_gnt[1]=1 following cycle.
REQ-037 Issue ids 3,0,1 then i_dp_rvalid with 8'hA0,8'hA1,8'hA2 -> o_rsp_valid 4'b1000,4'b0001,4'b0010 with matching data, one cycle after each.
REQ-038 i_dp_rvalid=1 after reset with nothing outstanding -> no o_rsp_valid, o_err=1 held until reset.
REQ-039 reset asserted mid-burst with 2 outstanding -> all outputs 0 same cycle, FSM ARB, first grant afterwards to lowest requesting index.
